uart_rx_fifo: RTL and testbench

Parametrised UART receiver: the successor to the fixed 8N1 receiver in the UART protocol path. It adds configurable data width, parity, stop bits and oversampling, an input synchroniser, and parity/framing/break detection. Received words are held in an internal FIFO and delivered through a valid/ready stream to the fibonacci microprocessor's command decoder. It consumes the same `tick` strobe from the baud rate generator.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync_fifo.sv | 45 ++++
 rtl/uart_rx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART path: parity mode, receiver FSM states and per-word error flags.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_RECOVER
  } rx_state_t;

  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } rx_flags_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; rdata is the head whenever !empty.
// A push while full is ignored unless a pop lands in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // When full, the write slot is the head being popped this same edge.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parameterised UART receiver: 2-flop sync, oversampled FSM, FWFT word FIFO carrying error flags.
// m_valid rises one clk after the final stop-sample tick; a frame finishing while the FIFO is full is dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      OVERSAMPLE = 16,
  parameter int      FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 m_break,
  output logic                 overrun,
  output logic                 rx_busy
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam int FW   = DATA_BITS + 3;
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  logic                 rx_meta, rx_s;
  rx_state_t            state_q, state_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BC_W-1:0]      bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_bit_q, par_err_q, frm_err_q;
  logic                 start_en, shift_en, par_en, stop_en, push;
  logic                 frm_now, stop_last;
  rx_flags_t            wflags, rflags;
  logic [FW-1:0]        fifo_rdata;
  logic                 fifo_full, fifo_empty, fifo_pop;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign frm_now   = frm_err_q || !rx_s;
  assign stop_last = (STOP_BITS == 1) || stop_q;

  always_comb begin
    state_d  = state_q;
    os_d     = os_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    start_en = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    stop_en  = 1'b0;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d  = ST_START;
          os_d     = '0;
          start_en = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (os_q == OS_MID) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              os_d    = '0;
              bit_d   = '0;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            shift_en = 1'b1;
            os_d     = '0;
            bit_d    = bit_q + BC_W'(1);
            if (bit_q == BC_LAST) begin
              state_d = HAS_PAR ? ST_PARITY : ST_STOP;
              stop_d  = 1'b0;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            par_en  = 1'b1;
            os_d    = '0;
            stop_d  = 1'b0;
            state_d = ST_STOP;
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (os_q == OS_LAST) begin
            stop_en = 1'b1;
            os_d    = '0;
            if (stop_last) begin
              push    = 1'b1;
              state_d = frm_now ? ST_RECOVER : ST_IDLE;
            end else begin
              stop_d = 1'b1;
            end
          end else begin
            os_d = os_q + OS_W'(1);
          end
        end
      end
      // Hold off until the line returns high so a long break yields a single word.
      ST_RECOVER: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shreg_q   <= '0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (start_en) begin
        par_bit_q <= 1'b0;
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
      end
      if (shift_en) shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
      if (par_en) begin
        par_bit_q <= rx_s;
        par_err_q <= (PARITY == PAR_ODD) ? ~(^shreg_q ^ rx_s) : (^shreg_q ^ rx_s);
      end
      if (stop_en && !rx_s) frm_err_q <= 1'b1;
      overrun <= push && fifo_full && !fifo_pop;
    end
  end

  always_comb begin
    wflags            = '0;
    wflags.parity_err = par_err_q;
    wflags.frame_err  = frm_now;
    wflags.brk        = frm_now && (shreg_q == '0) && (!HAS_PAR || !par_bit_q);
  end

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push),
    .wdata  ({wflags, shreg_q}),
    .full   (fifo_full),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty)
  );

  // Gate the head with m_valid so stale/unreset RAM never reaches the outputs.
  assign m_valid      = !fifo_empty;
  assign fifo_pop     = m_valid && m_ready;
  assign rflags       = rx_flags_t'(fifo_rdata[FW-1:DATA_BITS]);
  assign m_data       = m_valid ? fifo_rdata[DATA_BITS-1:0] : '0;
  assign m_parity_err = m_valid && rflags.parity_err;
  assign m_frame_err  = m_valid && rflags.frame_err;
  assign m_break      = m_valid && rflags.brk;
  assign rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 defaults (a), 7E1 (b) and 8N2 (c) receivers sharing clk, tick and reset.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int BIT_CYC = 64; // 16 ticks per bit, one tick every 4 clk

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic tick = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;
  logic mv_a, mv_b, mv_c;
  logic [7:0] md_a, md_c;
  logic [6:0] md_b;
  logic pe_a, fe_a, br_a, ov_a, bz_a;
  logic pe_b, fe_b, br_b, ov_b, bz_b;
  logic pe_c, fe_c, br_c, ov_c, bz_c;

  int n_cmp = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  int tcnt = 0;
  logic last_tick = 1'b0;
  logic mv_a_prev = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo u_a (
    .clk(clk), .arst_n(arst_n), .tick(tick), .rx(rx_a),
    .m_valid(mv_a), .m_ready(rdy_a), .m_data(md_a),
    .m_parity_err(pe_a), .m_frame_err(fe_a), .m_break(br_a),
    .overrun(ov_a), .rx_busy(bz_a)
  );

  uart_rx_fifo #(.DATA_BITS(7), .PARITY(PAR_EVEN)) u_b (
    .clk(clk), .arst_n(arst_n), .tick(tick), .rx(rx_b),
    .m_valid(mv_b), .m_ready(rdy_b), .m_data(md_b),
    .m_parity_err(pe_b), .m_frame_err(fe_b), .m_break(br_b),
    .overrun(ov_b), .rx_busy(bz_b)
  );

  uart_rx_fifo #(.STOP_BITS(2)) u_c (
    .clk(clk), .arst_n(arst_n), .tick(tick), .rx(rx_c),
    .m_valid(mv_c), .m_ready(rdy_c), .m_data(md_c),
    .m_parity_err(pe_c), .m_frame_err(fe_c), .m_break(br_c),
    .overrun(ov_c), .rx_busy(bz_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rx(input int ch, input logic v);
    case (ch)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send_bits(input int ch, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(ch, bits[i]);
      repeat (BIT_CYC) @(negedge clk);
    end
    set_rx(ch, 1'b1);
  endtask

  task automatic idle(input int nbits);
    repeat (nbits * BIT_CYC) @(negedge clk);
  endtask

  task automatic pop(input int ch);
    case (ch)
      0:       rdy_a = 1'b1;
      1:       rdy_b = 1'b1;
      default: rdy_c = 1'b1;
    endcase
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    rdy_c = 1'b0;
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  initial forever begin
    @(negedge clk);
    tcnt++;
    tick = (tcnt % 4 == 0);
  end

  initial forever begin
    @(posedge clk);
    last_tick = tick;
  end

  // Every new head on channel a must appear the cycle after a tick edge.
  initial forever begin
    @(negedge clk);
    if (arst_n) begin
      if (mv_a && !mv_a_prev) check("a_valid_after_tick", last_tick, 1);
      if (ov_a) ovr_cnt++;
    end
    mv_a_prev = mv_a;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] d;

    repeat (3) @(negedge clk);
    check("rst_valid", mv_a, 0);
    check("rst_data", md_a, 0);
    check("rst_flags", {br_a, fe_a, pe_a}, 0);
    check("rst_overrun", ov_a, 0);
    check("rst_busy", bz_a, 0);
    arst_n = 1'b1;
    idle(1);

    send_bits(0, f8n1(8'hA5), 10);
    check("a5_valid", mv_a, 1);
    check("a5_data", md_a, 8'hA5);
    check("a5_flags", {br_a, fe_a, pe_a}, 0);
    check("a5_busy_done", bz_a, 0);
    idle(1);
    check("a5_hold", md_a, 8'hA5);
    pop(0);
    check("a5_popped", mv_a, 0);

    set_rx(0, 1'b0);
    repeat (12) @(negedge clk);
    check("glitch_busy", bz_a, 1);
    repeat (4) @(negedge clk);
    set_rx(0, 1'b1);
    idle(1);
    check("glitch_idle", bz_a, 0);
    check("glitch_no_word", mv_a, 0);

    set_rx(0, 1'b0);
    idle(12);
    check("brk_recover", bz_a, 1);
    check("brk_valid", mv_a, 1);
    check("brk_data", md_a, 0);
    check("brk_flags", {br_a, fe_a, pe_a}, 3'b110);
    set_rx(0, 1'b1);
    repeat (8) @(negedge clk);
    check("brk_back_idle", bz_a, 0);
    pop(0);
    idle(1);
    send_bits(0, f8n1(8'h55), 10);
    check("after_brk_data", md_a, 8'h55);
    check("after_brk_flags", {br_a, fe_a, pe_a}, 0);
    pop(0);

    ovr_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      d = k[7:0];
      send_bits(0, f8n1(d), 10);
    end
    check("fill_no_overrun", ovr_cnt, 0);
    send_bits(0, f8n1(8'h05), 10);
    idle(1);
    check("overrun_pulses", ovr_cnt, 1);
    rdy_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_valid", mv_a, 1);
      check("drain_data", md_a, k);
      @(negedge clk);
    end
    rdy_a = 1'b0;
    check("drain_empty", mv_a, 0);

    // Fill, then pop on exactly the push edge: 8 + 8*16 + 16 = 152 ticks after START entry.
    for (int k = 8'h11; k <= 8'h14; k++) begin
      d = k[7:0];
      send_bits(0, f8n1(d), 10);
    end
    ovr_cnt = 0;
    fork
      send_bits(0, f8n1(8'h15), 10);
      begin
        repeat (3) @(posedge clk);
        n = 0;
        while (n < 151) begin
          @(posedge clk);
          if (tick) n++;
        end
        repeat (3) @(posedge clk);
        #1 rdy_a = 1'b1;
        @(posedge clk);
        #1 rdy_a = 1'b0;
      end
    join
    idle(1);
    check("fullpop_no_overrun", ovr_cnt, 0);
    rdy_a = 1'b1;
    for (int k = 8'h12; k <= 8'h15; k++) begin
      check("fullpop_data", md_a, k);
      @(negedge clk);
    end
    rdy_a = 1'b0;
    check("fullpop_empty", mv_a, 0);

    send_bits(1, {6'b0, 1'b1, 1'b1, 7'h3C, 1'b0}, 10);
    check("par_bad_valid", mv_b, 1);
    check("par_bad_data", md_b, 7'h3C);
    check("par_bad_flags", {br_b, fe_b, pe_b}, 3'b001);
    pop(1);
    send_bits(1, {6'b0, 1'b1, 1'b0, 7'h3C, 1'b0}, 10);
    check("par_ok_data", md_b, 7'h3C);
    check("par_ok_flags", {br_b, fe_b, pe_b}, 0);
    pop(1);
    send_bits(1, {6'b0, 1'b1, 1'b1, 7'h3D, 1'b0}, 10);
    check("par_ok2_data", md_b, 7'h3D);
    check("par_ok2_flags", {br_b, fe_b, pe_b}, 0);
    pop(1);

    fork
      send_bits(2, {5'b0, 2'b11, 8'h9A, 1'b0}, 11);
      begin
        idle(3);
        check("c_busy_mid", bz_c, 1);
        arst_n = 1'b0;
        @(negedge clk);
        check("c_rst_valid", mv_c, 0);
        check("c_rst_data", md_c, 0);
        check("c_rst_flags", {br_c, fe_c, pe_c}, 0);
        check("c_rst_busy", bz_c, 0);
        check("c_rst_overrun", ov_c, 0);
      end
    join
    idle(1);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("c_post_rst_empty", mv_c, 0);
    check("c_post_rst_ovr", ov_c, 0);
    send_bits(2, {5'b0, 2'b11, 8'h9A, 1'b0}, 11);
    check("c_9a_valid", mv_c, 1);
    check("c_9a_data", md_c, 8'h9A);
    check("c_9a_flags", {br_c, fe_c, pe_c}, 0);
    pop(2);
    send_bits(2, {5'b0, 2'b01, 8'h9A, 1'b0}, 11);
    check("c_stop2_data", md_c, 8'h9A);
    check("c_stop2_flags", {br_c, fe_c, pe_c}, 3'b010);
    pop(2);
    repeat (8) @(negedge clk);
    check("c_stop2_idle", bz_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
